// File: rtl/uart_alu_intf.sv
// uart_alu_intf: collects operand A, operand B and opcode bytes from the UART
// receiver, presents them as registered ALU operands, captures the ALU result
// and requests one transmission. An optional inter-byte timeout abandons
// partial frames.
module uart_alu_intf #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_drop,
    output logic               o_timeout
);

    // One-hot state encoding
    localparam logic [5:0] ST_WAIT_A  = 6'b000001;
    localparam logic [5:0] ST_WAIT_B  = 6'b000010;
    localparam logic [5:0] ST_WAIT_OP = 6'b000100;
    localparam logic [5:0] ST_EXEC    = 6'b001000;
    localparam logic [5:0] ST_SEND    = 6'b010000;
    localparam logic [5:0] ST_WAIT_TX = 6'b100000;

    // Counter only needs to reach TIMEOUT_CYC-1; keep at least one bit so
    // the disabled configuration still elaborates.
    localparam int                CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [5:0]       state;
    logic [5:0]       state_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic             in_frame;
    logic             to_hit;

    assign in_frame = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign to_hit   = (TIMEOUT_CYC != 0) && in_frame && !i_rx_done && (to_cnt == CNT_LAST);
    assign o_busy   = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);

    // Next-state decode; any illegal encoding falls back to WAIT_A.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_A:  if (i_rx_done) state_nxt = ST_WAIT_B;
            ST_WAIT_B:  if (i_rx_done) state_nxt = ST_WAIT_OP;
                        else if (to_hit) state_nxt = ST_WAIT_A;
            ST_WAIT_OP: if (i_rx_done) state_nxt = ST_EXEC;
                        else if (to_hit) state_nxt = ST_WAIT_A;
            ST_EXEC:    state_nxt = ST_SEND;
            ST_SEND:    state_nxt = ST_WAIT_TX;
            ST_WAIT_TX: if (i_tx_done) state_nxt = ST_WAIT_A;
            default:    state_nxt = ST_WAIT_A;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_WAIT_A;
        else          state <= state_nxt;
    end

    // Inter-byte timer: runs only while a frame is partially assembled and
    // restarts on every accepted byte.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            to_cnt <= '0;
        else if ((TIMEOUT_CYC == 0) || !in_frame || i_rx_done || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    // Operand/result capture and single-cycle status pulses.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_drop     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            if ((state == ST_WAIT_A) && i_rx_done)  o_alu_a  <= i_rx_data;
            if ((state == ST_WAIT_B) && i_rx_done)  o_alu_b  <= i_rx_data;
            if ((state == ST_WAIT_OP) && i_rx_done) o_alu_op <= i_rx_data[NB_OP-1:0];
            if (state == ST_EXEC)                   o_tx_data <= i_alu_result;
            // High for exactly the SEND cycle, result already latched.
            o_tx_start <= (state == ST_EXEC);
            o_drop     <= i_rx_done && o_busy;
            o_timeout  <= to_hit;
        end
    end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Bench for uart_alu_intf: directed vector table, multi-cycle corner
// sequences (timeout, reset abort) and randomized frames against a
// frame-level model of the byte protocol and ALU.
module tb_uart_alu_intf;

    logic       clk;
    logic       i_rst_n;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_drop;
    logic       o_timeout;

    int n_vec, n_err;
    int n_start, n_drop, n_tmo;
    int exp_starts, exp_drops, exp_tmos;

    uart_alu_intf #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy),
        .o_drop(o_drop), .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU, also used as the environment's combinational ALU.
    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu(o_alu_a, o_alu_b, o_alu_op);

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (o_tx_start) n_start++;
        if (o_drop)     n_drop++;
        if (o_timeout)  n_tmo++;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_a"},     32'(o_alu_a),    0);
        check({nm, "_b"},     32'(o_alu_b),    0);
        check({nm, "_op"},    32'(o_alu_op),   0);
        check({nm, "_txd"},   32'(o_tx_data),  0);
        check({nm, "_start"}, 32'(o_tx_start), 0);
        check({nm, "_busy"},  32'(o_busy),     0);
        check({nm, "_drop"},  32'(o_drop),     0);
        check({nm, "_tmo"},   32'(o_timeout),  0);
    endtask

    // Full frame; drop=1 injects a byte in WAIT_TX, drop=2 injects one in EXEC.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                             input logic [7:0] exp_tx, input logic [5:0] exp_op,
                             input int drop, input int gap);
        send_byte(a);
        idle(gap);
        send_byte(b);
        idle(gap);
        send_byte(opb);
        check("exec_busy",  32'(o_busy), 1);
        check("exec_start", 32'(o_tx_start), 0);
        check("alu_a",      32'(o_alu_a), 32'(a));
        check("alu_b",      32'(o_alu_b), 32'(b));
        check("alu_op",     32'(o_alu_op), 32'(exp_op));
        if (drop == 2) begin
            i_rx_data = 8'h55;
            i_rx_done = 1'b1;
            exp_drops++;
        end
        step();
        i_rx_done = 1'b0;
        if (drop == 2) check("drop_exec", 32'(o_drop), 1);
        check("tx_start", 32'(o_tx_start), 1);
        check("tx_data",  32'(o_tx_data), 32'(exp_tx));
        exp_starts++;
        step();
        check("start_len", 32'(o_tx_start), 0);
        check("waittx_busy", 32'(o_busy), 1);
        if (drop == 1) begin
            send_byte(8'h99);
            check("drop_wtx", 32'(o_drop), 1);
            exp_drops++;
            step();
            check("drop_len", 32'(o_drop), 0);
        end
        check("drop_keep_a", 32'(o_alu_a), 32'(a));
        check("drop_keep_op", 32'(o_alu_op), 32'(exp_op));
        idle(gap);
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        check("done_busy", 32'(o_busy), 0);
        check("tx_hold",   32'(o_tx_data), 32'(exp_tx));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [7:0] exp_tx;
        logic [5:0] exp_op;
        int         drop;
    } vec_t;

    vec_t tbl[10];

    initial begin
        n_vec = 0; n_err = 0;
        n_start = 0; n_drop = 0; n_tmo = 0;
        exp_starts = 0; exp_drops = 0; exp_tmos = 0;

        tbl[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 6'h20, 0};
        tbl[1] = '{8'h05, 8'h03, 8'hE2, 8'h02, 6'h22, 0};
        tbl[2] = '{8'hF0, 8'h3C, 8'h24, 8'h30, 6'h24, 1};
        tbl[3] = '{8'hF0, 8'h0F, 8'h25, 8'hFF, 6'h25, 0};
        tbl[4] = '{8'hAA, 8'hFF, 8'h26, 8'h55, 6'h26, 2};
        tbl[5] = '{8'h00, 8'h00, 8'h27, 8'hFF, 6'h27, 0};
        tbl[6] = '{8'hFF, 8'h01, 8'h20, 8'h00, 6'h20, 0};
        tbl[7] = '{8'h80, 8'h02, 8'h03, 8'hE0, 6'h03, 0};
        tbl[8] = '{8'h80, 8'h02, 8'hC2, 8'h20, 6'h02, 0};
        tbl[9] = '{8'h12, 8'h34, 8'h40, 8'h00, 6'h00, 0};

        i_rst_n = 1'b0; i_rx_data = '0; i_rx_done = 1'b0; i_tx_done = 1'b0;
        #12;
        check_all_zero("reset");
        i_rst_n = 1'b1;
        step();

        // Directed table
        for (int i = 0; i < 10; i++)
            run_frame(tbl[i].a, tbl[i].b, tbl[i].opb, tbl[i].exp_tx, tbl[i].exp_op, tbl[i].drop, i % 3);

        // Stray tx_done while idle is ignored
        i_tx_done = 1'b1; step(); i_tx_done = 1'b0;
        check("stray_txdone_busy", 32'(o_busy), 0);

        // Timeout in WAIT_B: 100 cycles after A
        send_byte(8'hC3);
        idle(99);
        check("tmo_b_early", 32'(o_timeout), 0);
        step();
        check("tmo_b_pulse", 32'(o_timeout), 1);
        exp_tmos++;
        check("tmo_keep_a", 32'(o_alu_a), 32'hC3);
        step();
        check("tmo_b_len", 32'(o_timeout), 0);
        run_frame(8'h07, 8'h09, 8'h20, 8'h10, 6'h20, 0, 1);

        // Timeout in WAIT_OP
        send_byte(8'h11);
        send_byte(8'h66);
        idle(99);
        check("tmo_op_early", 32'(o_timeout), 0);
        step();
        check("tmo_op_pulse", 32'(o_timeout), 1);
        exp_tmos++;
        check("tmo_keep_b", 32'(o_alu_b), 32'h66);
        run_frame(8'h09, 8'h04, 8'h22, 8'h05, 6'h22, 0, 0);

        // Byte on the expiry cycle is accepted as B
        send_byte(8'h40);
        idle(99);
        send_byte(8'h02);
        check("edge_no_tmo", 32'(o_timeout), 0);
        check("edge_b",      32'(o_alu_b), 32'h02);
        send_byte(8'h22);
        step();
        check("edge_start", 32'(o_tx_start), 1);
        check("edge_data",  32'(o_tx_data), 32'h3E);
        exp_starts++;
        step();
        i_tx_done = 1'b1; step(); i_tx_done = 1'b0;

        // Reset during SEND: async clear, no start afterwards
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h20);
        step();
        check("rst_send_pre", 32'(o_tx_start), 1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_send");
        #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_send_nostart", 32'(o_tx_start), 0);
            check("rst_send_idle", 32'(o_busy), 0);
        end

        // Reset during WAIT_TX
        send_byte(8'h03); send_byte(8'h04); send_byte(8'h20);
        step();
        exp_starts++;
        step();
        check("rst_wtx_busy", 32'(o_busy), 1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_wtx");
        #1;
        i_rst_n = 1'b1;
        step();
        check("rst_wtx_nostart", 32'(o_tx_start), 0);
        run_frame(8'h21, 8'h12, 8'h20, 8'h33, 6'h20, 0, 2);

        // Randomized frames against the frame-level model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b, opb;
            logic [5:0] op;
            int drop;
            a    = 8'($urandom);
            b    = 8'($urandom);
            opb  = ($urandom_range(0, 1) == 0) ? 8'($urandom) :
                   {2'($urandom), 6'h20 | 6'($urandom_range(0, 7))};
            op   = opb[5:0];
            drop = $urandom_range(0, 4);
            if (drop > 2) drop = 0;
            run_frame(a, b, opb, alu(a, b, op), op, drop, $urandom_range(0, 5));
        end

        step();
        check("count_start", 32'(n_start), 32'(exp_starts));
        check("count_drop",  32'(n_drop),  32'(exp_drops));
        check("count_tmo",   32'(n_tmo),   32'(exp_tmos));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
